// File: rtl/tdt_dtm_dmi_ctrl.sv
// JTAG DTM register block: IR, IDCODE/BYPASS/DTMCS/DMI/DMI_ACC data registers
// and the DMI request FSM that hands bus transfers to the APB master.
module tdt_dtm_dmi_ctrl #(
  parameter int unsigned DTM_IRREG_WIDTH = 5,
  parameter int unsigned DTM_ABITS       = 16,
  parameter int unsigned CHAIN_DW        = DTM_ABITS + 34,
  parameter logic [31:0] IDCODE_VAL      = 32'h1000_0B6F,
  parameter logic [2:0]  IDLE_HINT       = 3'd1,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                       tclk,
  input  logic                       trst_b,
  input  logic                       ctrl_idr_capture_dr,
  input  logic                       ctrl_idr_update_dr,
  input  logic                       ctrl_idr_update_ir,
  input  logic [CHAIN_DW-1:0]        chain_idr_data,
  output logic [CHAIN_DW-1:0]        idr_chain_dr,
  output logic [DTM_IRREG_WIDTH-1:0] idr_chain_ir,
  output logic                       idr_bypass,
  output logic                       idr_dmi_mode,
  output logic                       dmihardreset,
  output logic                       dtm_apbm_wr_vld,
  output logic [DTM_ABITS-1:0]       dtm_apbm_wr_addr,
  output logic [1:0]                 dtm_apbm_wr_flg,
  output logic [31:0]                dtm_apbm_wdata,
  input  logic                       apbm_dtm_wr_ready,
  input  logic [31:0]                apbm_dtm_rdata,
  input  logic                       apbm_dtm_slverr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [5:0] ABITS6 = 6'(DTM_ABITS);

  localparam logic [DTM_IRREG_WIDTH-1:0] IR_IDCODE = DTM_IRREG_WIDTH'(5'h01);
  localparam logic [DTM_IRREG_WIDTH-1:0] IR_DMIACC = DTM_IRREG_WIDTH'(5'h02);
  localparam logic [DTM_IRREG_WIDTH-1:0] IR_DTMCS  = DTM_IRREG_WIDTH'(5'h10);
  localparam logic [DTM_IRREG_WIDTH-1:0] IR_DMI    = DTM_IRREG_WIDTH'(5'h11);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [CNT_W-1:0]             r_cnt;
  logic [CNT_W-1:0]             w_cnt_nxt;
  logic [DTM_IRREG_WIDTH-1:0]   r_ir;
  logic                         r_mode;
  logic                         r_hardreset;
  logic                         r_dmireset;
  logic [DTM_ABITS-1:0]         r_addr;
  logic [31:0]                  r_data;
  logic [1:0]                   r_op;
  logic [1:0]                   r_status;

  logic                         w_sel_idcode;
  logic                         w_sel_dmiacc;
  logic                         w_sel_dtmcs;
  logic                         w_sel_dmi;
  logic                         w_running;
  logic [1:0]                   w_op_in;
  logic                         w_op_valid;
  logic                         w_req_accept;
  logic                         w_cnt_hit;
  logic                         w_complete;
  logic                         w_timeout;
  logic                         w_busy;
  logic                         w_fail;
  logic                         w_rd_load;
  logic [CHAIN_DW-1:0]          w_dr;

  assign w_sel_idcode = (r_ir == IR_IDCODE);
  assign w_sel_dmiacc = (r_ir == IR_DMIACC);
  assign w_sel_dtmcs  = (r_ir == IR_DTMCS);
  assign w_sel_dmi    = (r_ir == IR_DMI);
  assign w_running    = (r_state != S_IDLE);
  assign w_op_in      = chain_idr_data[1:0];
  assign w_op_valid   = (w_op_in == 2'd1) || (w_op_in == 2'd2);

  assign w_req_accept = (r_state == S_IDLE) && ctrl_idr_update_dr && w_sel_dmi &&
                        w_op_valid && (r_status == 2'd0) && !r_mode && !r_hardreset;
  assign w_cnt_hit    = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  assign w_busy    = w_running && w_sel_dmi &&
                     (ctrl_idr_capture_dr || (ctrl_idr_update_dr && w_op_valid));
  assign w_fail    = w_timeout || (w_complete && apbm_dtm_slverr);
  assign w_rd_load = w_complete && !apbm_dtm_slverr && (r_op == 2'd1);

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A hard reset never abandons an issued transfer: REQ/WAIT fall into DRAIN
  // unless the response lands in the same cycle, which already retires it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_accept) w_state_nxt = S_REQ;
      end
      S_REQ, S_WAIT: begin
        if (apbm_dtm_wr_ready) begin
          w_state_nxt = S_IDLE;
          w_complete  = 1'b1;
        end else if (r_state == S_REQ) begin
          w_state_nxt = S_WAIT;
        end else if (w_cnt_hit) begin
          w_state_nxt = S_DRAIN;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (apbm_dtm_wr_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (r_hardreset) begin
      w_complete = 1'b0;
      w_timeout  = 1'b0;
      w_cnt_nxt  = '0;
      if ((r_state == S_REQ) || (r_state == S_WAIT))
        w_state_nxt = apbm_dtm_wr_ready ? S_IDLE : S_DRAIN;
    end
  end

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_hardreset <= 1'b0;
      r_dmireset  <= 1'b0;
    end else begin
      r_hardreset <= ctrl_idr_update_dr && w_sel_dtmcs && chain_idr_data[17];
      r_dmireset  <= ctrl_idr_update_dr && w_sel_dtmcs && chain_idr_data[16];
    end
  end

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_ir   <= IR_IDCODE;
      r_mode <= 1'b0;
    end else if (r_hardreset) begin
      r_ir   <= IR_IDCODE;
      r_mode <= 1'b0;
    end else begin
      if (ctrl_idr_update_ir) r_ir <= chain_idr_data[DTM_IRREG_WIDTH-1:0];
      if (ctrl_idr_update_dr && w_sel_dmiacc) r_mode <= chain_idr_data[0];
    end
  end

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_addr <= '0;
      r_data <= '0;
      r_op   <= '0;
    end else if (r_hardreset) begin
      r_addr <= '0;
      r_data <= '0;
      r_op   <= '0;
    end else if (w_req_accept) begin
      r_addr <= chain_idr_data[33+DTM_ABITS:34];
      r_data <= chain_idr_data[33:2];
      r_op   <= w_op_in;
    end else if (w_rd_load) begin
      r_data <= apbm_dtm_rdata;
    end
  end

  // Sticky: once non-zero it holds until an explicit clear; busy beats failed.
  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_status <= '0;
    end else if (r_hardreset || r_dmireset) begin
      r_status <= '0;
    end else if (r_status == 2'd0) begin
      if (w_busy)      r_status <= 2'd3;
      else if (w_fail) r_status <= 2'd2;
    end
  end

  always_comb begin
    w_dr = '0;
    if (w_sel_idcode)
      w_dr = CHAIN_DW'(IDCODE_VAL);
    else if (w_sel_dmiacc)
      w_dr = CHAIN_DW'(r_mode);
    else if (w_sel_dtmcs)
      w_dr = CHAIN_DW'({IDLE_HINT, r_status, ABITS6, 4'h1});
    else if (w_sel_dmi)
      w_dr = CHAIN_DW'({r_addr, r_data, (w_running ? 2'b11 : r_status)});
  end

  assign idr_chain_dr     = w_dr;
  assign idr_chain_ir     = r_ir;
  assign idr_bypass       = !(w_sel_idcode || w_sel_dmiacc || w_sel_dtmcs || w_sel_dmi);
  assign idr_dmi_mode     = r_mode;
  assign dmihardreset     = r_hardreset;
  assign dtm_apbm_wr_vld  = (r_state == S_REQ);
  assign dtm_apbm_wr_addr = r_addr;
  assign dtm_apbm_wr_flg  = r_op;
  assign dtm_apbm_wdata   = r_data;

endmodule

// File: tb/tb_tdt_dtm_dmi_ctrl.sv
// Self-checking bench for tdt_dtm_dmi_ctrl: IR decode table, directed DMI
// corner sequences and random transactions against a transaction-level model.
module tb_tdt_dtm_dmi_ctrl;
  localparam int unsigned AB = 16;
  localparam int unsigned DW = AB + 34;
  localparam int unsigned TO = 8;

  logic          tclk = 1'b0;
  logic          trst_b;
  logic          cap, upd_dr, upd_ir;
  logic [DW-1:0] chain;
  logic [DW-1:0] dr;
  logic [4:0]    ir;
  logic          bypass, mode, hreset, wr_vld;
  logic [AB-1:0] wr_addr;
  logic [1:0]    wr_flg;
  logic [31:0]   wdata;
  logic          ready, slverr;
  logic [31:0]   rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int vld_cnt = 0;

  tdt_dtm_dmi_ctrl #(
    .DTM_IRREG_WIDTH(5),
    .DTM_ABITS(AB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .tclk(tclk), .trst_b(trst_b),
    .ctrl_idr_capture_dr(cap), .ctrl_idr_update_dr(upd_dr), .ctrl_idr_update_ir(upd_ir),
    .chain_idr_data(chain), .idr_chain_dr(dr), .idr_chain_ir(ir),
    .idr_bypass(bypass), .idr_dmi_mode(mode), .dmihardreset(hreset),
    .dtm_apbm_wr_vld(wr_vld), .dtm_apbm_wr_addr(wr_addr), .dtm_apbm_wr_flg(wr_flg),
    .dtm_apbm_wdata(wdata), .apbm_dtm_wr_ready(ready), .apbm_dtm_rdata(rdata),
    .apbm_dtm_slverr(slverr)
  );

  always #5 tclk = ~tclk;
  always @(posedge tclk) if (wr_vld === 1'b1) vld_cnt <= vld_cnt + 1;

  typedef struct {
    logic [4:0]  ir;
    logic        byp;
    logic [63:0] dr;
  } ir_vec_t;
  ir_vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  task automatic set_ir(input logic [4:0] v);
    chain = DW'(v); upd_ir = 1'b1; tick(); upd_ir = 1'b0; chain = '0;
  endtask

  task automatic upd(input logic [63:0] v);
    chain = v[DW-1:0]; upd_dr = 1'b1; tick(); upd_dr = 1'b0; chain = '0;
  endtask

  function automatic logic [63:0] dmi(input logic [15:0] a, input logic [31:0] d,
                                      input logic [1:0] s);
    return {14'd0, a, d, s};
  endfunction

  function automatic logic [63:0] dtmcs(input logic [1:0] st);
    return 64'h1000 + (64'(st) << 10) + (64'(AB) << 4) + 64'h1;
  endfunction

  task automatic dmi_clear();
    set_ir(5'h10); upd(64'h1 << 16); tick(); tick(); set_ir(5'h11);
  endtask

  initial begin
    int v0;
    logic [15:0] m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_st;

    trst_b = 1'b0; cap = 0; upd_dr = 0; upd_ir = 0; chain = '0;
    ready = 0; slverr = 0; rdata = '0;
    tbl[0] = '{5'h01, 1'b0, 64'h1000_0B6F};
    tbl[1] = '{5'h1F, 1'b1, 64'h0};
    tbl[2] = '{5'h00, 1'b1, 64'h0};
    tbl[3] = '{5'h10, 1'b0, dtmcs(2'd0)};
    tbl[4] = '{5'h02, 1'b0, 64'h0};
    tbl[5] = '{5'h11, 1'b0, 64'h0};
    tbl[6] = '{5'h03, 1'b1, 64'h0};
    tbl[7] = '{5'h12, 1'b1, 64'h0};

    #12;
    chk("rst_ir", 64'(ir), 64'h1);
    chk("rst_dr", 64'(dr), 64'h1000_0B6F);
    chk("rst_outs", {58'd0, bypass, mode, hreset, wr_vld, wr_flg}, 64'h0);
    chk("rst_bus", {16'd0, wr_addr, wdata}, 64'h0);
    #10 trst_b = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      set_ir(tbl[i].ir);
      chk($sformatf("tbl%0d_ir", i), 64'(ir), 64'(tbl[i].ir));
      chk($sformatf("tbl%0d_byp", i), 64'(bypass), 64'(tbl[i].byp));
      chk($sformatf("tbl%0d_dr", i), 64'(dr), tbl[i].dr);
    end

    // DMI_ACC mode set blocks DMI requests
    set_ir(5'h02); upd(64'h1);
    chk("mode_set", {62'd0, mode, dr[0]}, 64'h3);
    set_ir(5'h11); v0 = vld_cnt; upd(dmi(16'h10, 32'h0, 2'd1)); tick(); tick();
    chk("mode_block", 64'(vld_cnt - v0), 64'h0);
    set_ir(5'h02); upd(64'h0);
    chk("mode_clr", 64'(mode), 64'h0);

    // read with 5-cycle latency
    set_ir(5'h11); v0 = vld_cnt;
    upd(dmi(16'h10, 32'h0, 2'd1));
    chk("rd_req", {45'd0, wr_vld, wr_addr, wr_flg}, {45'd0, 1'b1, 16'h10, 2'd1});
    tick();
    chk("rd_vld_1cyc", 64'(wr_vld), 64'h0);
    repeat (4) tick();
    ready = 1; rdata = 32'hDEAD_BEEF; tick(); ready = 0; rdata = '0;
    chk("rd_capture", 64'(dr), dmi(16'h10, 32'hDEAD_BEEF, 2'd0));
    chk("rd_vld_cnt", 64'(vld_cnt - v0), 64'h1);

    // write failing with slverr, then blocked, then dmireset
    upd(dmi(16'h20, 32'h55, 2'd2));
    chk("wr_req", {14'd0, wr_vld, wr_addr, wr_flg, wdata}, {14'd0, 1'b1, 16'h20, 2'd2, 32'h55});
    tick(); tick();
    ready = 1; slverr = 1; tick(); ready = 0; slverr = 0;
    chk("wr_err", 64'(dr), dmi(16'h20, 32'h55, 2'd2));
    v0 = vld_cnt; upd(dmi(16'h21, 32'h66, 2'd2)); tick(); tick();
    chk("wr_blocked", 64'(vld_cnt - v0), 64'h0);
    chk("wr_blocked_dr", 64'(dr), dmi(16'h20, 32'h55, 2'd2));
    set_ir(5'h10);
    chk("dtmcs_st2", 64'(dr), dtmcs(2'd2));
    upd(64'h1 << 16); tick(); tick();
    chk("dtmcs_clr", 64'(dr), dtmcs(2'd0));

    // capture and update while busy
    set_ir(5'h11); v0 = vld_cnt;
    upd(dmi(16'h30, 32'h0, 2'd1)); tick();
    cap = 1;
    chk("busy_cap_op", 64'(dr[1:0]), 64'h3);
    tick(); cap = 0;
    upd(dmi(16'h40, 32'h99, 2'd2));
    chk("busy_addr", 64'(wr_addr), 64'h30);
    ready = 1; rdata = 32'hCAFE_0001; tick(); ready = 0;
    chk("busy_final", 64'(dr), dmi(16'h30, 32'hCAFE_0001, 2'd3));
    chk("busy_vld_cnt", 64'(vld_cnt - v0), 64'h1);
    set_ir(5'h10);
    chk("dtmcs_st3", 64'(dr), dtmcs(2'd3));
    upd(64'h1 << 16); tick(); tick();
    chk("dtmcs_clr2", 64'(dr), dtmcs(2'd0));

    // timeout after TO WAIT cycles, late ready discarded
    set_ir(5'h11);
    upd(dmi(16'h44, 32'h77, 2'd1));
    set_ir(5'h10);
    repeat (TO - 1) tick();
    chk("to_before", 64'(dr), dtmcs(2'd0));
    tick();
    chk("to_hit", 64'(dr), dtmcs(2'd2));
    set_ir(5'h11);
    chk("to_drain", 64'(dr[1:0]), 64'h3);
    tick(); tick();
    ready = 1; rdata = 32'h1234; tick(); ready = 0;
    chk("to_late", 64'(dr), dmi(16'h44, 32'h77, 2'd2));
    dmi_clear();

    // hard reset during WAIT
    upd(dmi(16'h50, 32'h11, 2'd1));
    set_ir(5'h10);
    upd(64'h1 << 17);
    chk("hr_pulse", 64'(hreset), 64'h1);
    tick();
    chk("hr_selfclr", 64'(hreset), 64'h0);
    chk("hr_ir", 64'(ir), 64'h1);
    set_ir(5'h11);
    chk("hr_drain", 64'(dr), 64'h3);
    v0 = vld_cnt;
    repeat (TO + 2) tick();
    chk("hr_still_drain", 64'(dr), 64'h3);
    ready = 1; rdata = 32'hBAD; tick(); ready = 0;
    chk("hr_resp_ignored", 64'(dr), 64'h0);
    upd(dmi(16'h60, 32'h5A, 2'd2));
    chk("hr_new_req", {45'd0, wr_vld, wr_addr, wr_flg}, {45'd0, 1'b1, 16'h60, 2'd2});
    ready = 1; tick(); ready = 0;
    chk("hr_new_done", 64'(dr), dmi(16'h60, 32'h5A, 2'd0));
    chk("hr_vld_cnt", 64'(vld_cnt - v0), 64'h1);

    // random transactions against a transaction-level model
    m_addr = 16'h60; m_data = 32'h5A; m_st = 2'd0;
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  op;
      logic [15:0] a;
      logic [31:0] d, rd;
      int unsigned lat, capc;
      logic slv, cap_mid, busy, accept, tmo;
      op = 2'($urandom % 4); a = 16'($urandom); d = $urandom; rd = $urandom;
      lat = $urandom_range(12, 0); slv = ($urandom % 4) == 0;
      cap_mid = (lat >= 1) && (($urandom % 3) == 0);
      capc = (lat >= 1) ? $urandom_range(lat, 1) : 0;
      accept = (m_st == 2'd0) && (op == 2'd1 || op == 2'd2);
      v0 = vld_cnt;
      upd(dmi(a, d, op));
      if (accept) begin
        chk($sformatf("r%0d_req", t), {14'd0, wr_vld, wr_addr, wr_flg, wdata}, {14'd0, 1'b1, a, op, d});
        busy = 1'b0;
        for (int unsigned k = 0; k <= lat; k++) begin
          ready = (k == lat); rdata = ready ? rd : $urandom;
          slverr = ready ? slv : 1'($urandom);
          cap = cap_mid && (k == capc);
          if (cap) begin
            busy = 1'b1;
            chk($sformatf("r%0d_capop", t), 64'(dr[1:0]), 64'h3);
          end
          tick();
          cap = 0;
        end
        ready = 0; slverr = 0;
        tmo = lat > TO;
        m_addr = a; m_data = d;
        if (!tmo && !slv && op == 2'd1) m_data = rd;
        if (busy && (!tmo || capc <= TO)) m_st = 2'd3;
        else if (tmo || slv)              m_st = 2'd2;
        else                              m_st = 2'd0;
      end else begin
        tick();
      end
      chk($sformatf("r%0d_vld", t), 64'(vld_cnt - v0), 64'(accept));
      chk($sformatf("r%0d_dmi", t), 64'(dr), dmi(m_addr, m_data, m_st));
      if (m_st != 2'd0 && ($urandom % 2) == 0) begin
        dmi_clear();
        m_st = 2'd0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/tdt_dtm_dmi_ctrl.md
# tdt_dtm_dmi_ctrl

Parametrised JTAG Debug Transport Module register block. It holds the IR and the IDCODE, BYPASS, DTMCS, DMI and DMI_ACC data registers. It issues DMI requests to the APB master and records their completion status. Compared with the previous generation it adds a configurable address width and IDCODE, a BYPASS register, an error (status 2) path from the bus, a request timeout, and a hard reset that cannot orphan an in-flight bus transfer. It sits between the TAP controller/shift chain and the DTM APB master in the `tdt` debug subsystem.

## Interface
- DTM_IRREG_WIDTH, 5, IR width (≥5)
- DTM_ABITS, 16, DMI address width, 7..32
- CHAIN_DW, DTM_ABITS+34, shift-chain data width
- IDCODE_VAL, 32'h1000_0B6F, IDCODE register value
- IDLE_HINT, 3'd1, DTMCS.idle field
- TIMEOUT_CYCLES, 1024, tclk cycles waiting for ready before failing; 0 disables timeout
- tclk  in  1  TAP clock; single clock domain
- trst_b  in  1  asynchronous active-low reset
- ctrl_idr_capture_dr / ctrl_idr_update_dr / ctrl_idr_update_ir  in  1 each  one-cycle TAP state strobes
- chain_idr_data  in  CHAIN_DW  shifted-in value (IR in LSBs for update_ir)
- idr_chain_dr  out  CHAIN_DW  parallel-load value for capture
- idr_chain_ir  out  DTM_IRREG_WIDTH  current IR
- idr_bypass  out  1  high when the selected DR is the 1-bit BYPASS
- idr_dmi_mode  out  1  DMI_ACC mode bit
- dmihardreset  out  1  one-cycle hard-reset pulse
- dtm_apbm_wr_vld  out  1  one-cycle request pulse
- dtm_apbm_wr_addr  out  DTM_ABITS; dtm_apbm_wr_flg  out  2 (1=read, 2=write); dtm_apbm_wdata  out  32
- apbm_dtm_wr_ready  in  1  response strobe; apbm_dtm_rdata  in  32; apbm_dtm_slverr  in  1  qualifies ready

## Operation
- IR decode: 0x01 IDCODE, 0x02 DMI_ACC, 0x10 DTMCS, 0x11 DMI, all others BYPASS.
  - BYPASS: idr_bypass=1 and idr_chain_dr=0.
  - IR loads chain_idr_data on update_ir and resets to IDCODE on dmihardreset.
- DTMCS read value: {0…, IDLE_HINT[14:12], dmistat[11:10], DTM_ABITS[9:4], 4'h1}.
  - An update writing bit16 (dmireset) clears the sticky status next cycle.
  - An update writing bit17 (dmihardreset) produces the dmihardreset pulse.
- DMI_ACC: bit0 is the mode register; update writes it.
- FSM states:
  - IDLE: accepts a DMI update with op∈{1,2}, status==0 and mode==0. It latches addr=[33+DTM_ABITS:34], data=[33:2], op=[1:0], then goes to REQ. Op 0 and op 3 are no-ops.
  - REQ: wr_vld=1 for exactly this cycle, then WAIT.
  - WAIT: the timeout counter increments each cycle.
    - On ready with slverr=0: read loads rdata into data; write leaves data unchanged. Go to IDLE.
    - On ready with slverr=1: status←2 and data unchanged. Go to IDLE.
    - On counter == TIMEOUT_CYCLES-1 without ready: status←2, go to DRAIN.
  - DRAIN: waits for ready, discarding rdata and slverr, then goes to IDLE.
- dmi_req_running = state≠IDLE.
  - capture_dr on DMI while running loads op field 3 and sets status←3.
  - update_dr on DMI with op∈{1,2} while running sets status←3 and changes no request registers.
- Sticky status: 0 ok, 2 failed, 3 busy.
  - It only moves away from 0 (3 overrides 2 in the same cycle).
  - It clears on dmireset or dmihardreset.
  - When status≠0, new requests are ignored.
- DMI capture value: {addr, data, status}, or op field 3 while running.
- dmihardreset pulse effects:
  - Clears IR (to IDCODE), mode, addr, data, op, status and the counter.
  - REQ or WAIT goes to DRAIN; IDLE and DRAIN are unchanged.
  - The outstanding APB transfer always completes, and its response is ignored.

## Timing
- Reset values:
  - IR=IDCODE; all other outputs 0; state IDLE.
  - idr_chain_dr = {0…, IDCODE_VAL}.
- Request latency: update_dr at cycle N → wr_vld at N+1 → running from N+1 onward.
- Ready at cycle M → data/status updated at M+1 → state IDLE at M+1. The next update is accepted from M+1.
- dmihardreset register sets the cycle after the DTMCS update and self-clears after 1 cycle. dmireset behaves the same way.
- Ready arriving in REQ is legal and treated as a WAIT completion.
- The timeout counter is DTM_ABITS-independent, clog2(TIMEOUT_CYCLES+1) wide, and cleared on leaving WAIT.
- Simultaneous capture-while-running and ready: capture sees busy, and status becomes 3.
- trst_b assertion mid-transfer: asynchronous clear of everything; no drain is guaranteed.

## Test plan
- Reset, then capture with IR=IDCODE → dr=0x1000_0B6F; set IR=0x1F → idr_bypass=1, dr=0.
- DMI read addr 0x10 → wr_vld 1 cycle with flg=1; ready with rdata 0xDEAD_BEEF after 5 cycles; next capture → {0x10, 0xDEADBEEF, 0}.
- Write with slverr=1 on ready → status 2; a new write is ignored (no wr_vld); DTMCS bit16 → status 0.
- Capture during WAIT → op field 3, dmistat=3; a following update with op=2 is ignored; addr is stable.
- TIMEOUT_CYCLES=8 with ready withheld → status 2 at cycle 8 of WAIT, state DRAIN; a late ready with rdata 0x1234 leaves data unchanged.
- dmihardreset in WAIT → IR=IDCODE, status 0, state DRAIN; a new request is blocked until ready, then accepted.
